// File: rtl/pixel_read_port.sv
// rtl/pixel_read_port.sv - burst pixel reader between the address registers and the data RAM
module pixel_read_port #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [7:0]        len,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic [DATA_W-1:0] pix,
    output logic              pix_vld,
    output logic              inc_req,
    output logic              busy,
    output logic              done
);

    // Wide enough for RD_LAT-1 with RD_LAT up to 7.
    localparam int LAT_W = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_CAPT  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t            state_q,    state_d;
    logic [LAT_W-1:0]  lat_cnt_q,  lat_cnt_d;
    logic [7:0]        beats_q,    beats_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q,   mem_rd_d;
    logic [DATA_W-1:0] pix_q,      pix_d;
    logic              pix_vld_q,  pix_vld_d;
    logic              inc_req_q,  inc_req_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    // Every output comes straight from a register; nothing combinational reaches the ports.
    assign mem_addr = mem_addr_q;
    assign mem_rd   = mem_rd_q;
    assign pix      = pix_q;
    assign pix_vld  = pix_vld_q;
    assign inc_req  = inc_req_q;
    assign busy     = busy_q;
    assign done     = done_q;

    // Next-state and registered-output decode; strobes default low so each lasts one clock.
    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        beats_d    = beats_q;
        mem_addr_d = mem_addr_q;
        pix_d      = pix_q;
        busy_d     = busy_q;
        mem_rd_d   = 1'b0;
        pix_vld_d  = 1'b0;
        inc_req_d  = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    // Address is owned internally from here on; addr_in is not looked at again.
                    mem_addr_d = addr_in;
                    beats_d    = (len == 8'd0) ? 8'd1 : len;
                    busy_d     = 1'b1;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_rd_d  = 1'b1;
                lat_cnt_d = LAT_W'(RD_LAT - 1);
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // The strobe is visible the clock after ISSUE, so data lands RD_LAT clocks later.
                if (lat_cnt_q == '0) begin
                    state_d = S_CAPT;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            S_CAPT: begin
                pix_d      = mem_dout;
                pix_vld_d  = 1'b1;
                inc_req_d  = 1'b1;
                mem_addr_d = mem_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                beats_d    = beats_q - 8'd1;
                if (beats_q == 8'd1) begin
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_FIN: begin
                // Start is deliberately not sampled here; it is seen again from IDLE.
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State register on the falling edge, in step with the datapath registers; reset aborts any burst.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lat_cnt_q  <= '0;
            beats_q    <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            pix_q      <= '0;
            pix_vld_q  <= 1'b0;
            inc_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            beats_q    <= beats_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            pix_q      <= pix_d;
            pix_vld_q  <= pix_vld_d;
            inc_req_q  <= inc_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_pixel_read_port.sv
// tb/tb_pixel_read_port.sv - directed bench for pixel_read_port
module tb_pixel_read_port;

    logic        clk;
    logic        rst;
    logic        start;
    logic [17:0] addr_in;
    logic [7:0]  len;
    logic [7:0]  mem_dout;
    logic [17:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  pix;
    logic        pix_vld;
    logic        inc_req;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    pixel_read_port #(.ADDR_W(18), .DATA_W(8), .RD_LAT(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .addr_in  (addr_in),
        .len      (len),
        .mem_dout (mem_dout),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .pix      (pix),
        .pix_vld  (pix_vld),
        .inc_req  (inc_req),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM contents: location 7 holds 0xA5, otherwise low byte of address xor top two address bits.
    function automatic logic [7:0] ram_word(input logic [17:0] a);
        if (a == 18'h00007) return 8'hA5;
        return a[7:0] ^ {6'b000000, a[17:16]};
    endfunction

    // Two-stage read pipeline on the same falling edge as the DUT: data valid two clocks after the strobe.
    logic [7:0] ram_s1;
    logic [7:0] ram_s2;
    always @(negedge clk) begin
        if (mem_rd) ram_s1 <= ram_word(mem_addr);
        ram_s2 <= ram_s1;
    end
    assign mem_dout = ram_s2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // One DUT edge (falling) between successive rising-edge sample points.
    task automatic step();
        @(posedge clk);
    endtask

    task automatic start_burst(input string tag, input logic [17:0] a, input logic [7:0] l);
        addr_in = a;
        len     = l;
        start   = 1'b1;
        step();
        check({tag, " busy@accept"}, 32'(busy), 32'd1);
        check({tag, " latch addr"}, 32'(mem_addr), 32'(a));
        start = 1'b0;
    endtask

    // Checks one beat clock by clock, starting from the edge that entered ISSUE.
    task automatic do_beat(input string tag, input logic [17:0] a, input logic [7:0] p, input bit last);
        step();
        check({tag, " mem_rd"}, 32'(mem_rd), 32'd1);
        check({tag, " mem_addr"}, 32'(mem_addr), 32'(a));
        check({tag, " inc_req low"}, 32'(inc_req), 32'd0);
        step();
        check({tag, " mem_rd 1clk"}, 32'(mem_rd), 32'd0);
        step();
        check({tag, " early vld"}, 32'(pix_vld), 32'd0);
        step();
        check({tag, " pix_vld"}, 32'(pix_vld), 32'd1);
        check({tag, " pix"}, 32'(pix), 32'(p));
        check({tag, " inc_req"}, 32'(inc_req), 32'd1);
        check({tag, " done"}, 32'(done), 32'(last));
        check({tag, " busy"}, 32'(busy), 32'd1);
        if (last) begin
            step();
            check({tag, " busy drop"}, 32'(busy), 32'd0);
            check({tag, " vld drop"}, 32'(pix_vld), 32'd0);
            check({tag, " pix hold"}, 32'(pix), 32'(p));
            check({tag, " final addr"}, 32'(mem_addr), 32'(a + 18'd1));
        end
    endtask

    initial begin
        bit stray;
        rst     = 1'b1;
        start   = 1'b1;
        addr_in = 18'h00003;
        len     = 8'd1;
        @(posedge clk);

        // Reset for two clocks with start asserted: start must be ignored.
        step();
        step();
        check("rst busy", 32'(busy), 32'd0);
        check("rst mem_rd", 32'(mem_rd), 32'd0);
        check("rst pix_vld", 32'(pix_vld), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst inc_req", 32'(inc_req), 32'd0);
        check("rst mem_addr", 32'(mem_addr), 32'd0);
        check("rst pix", 32'(pix), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        step();
        check("post-rst busy", 32'(busy), 32'd0);
        check("post-rst mem_addr", 32'(mem_addr), 32'd0);

        // Single beat from location 7.
        start_burst("t2", 18'h00007, 8'd1);
        do_beat("t2 b0", 18'h00007, 8'hA5, 1'b1);

        // Four beats from 0x10.
        start_burst("t3", 18'h00010, 8'd4);
        do_beat("t3 b0", 18'h00010, 8'h10, 1'b0);
        do_beat("t3 b1", 18'h00011, 8'h11, 1'b0);
        do_beat("t3 b2", 18'h00012, 8'h12, 1'b0);
        do_beat("t3 b3", 18'h00013, 8'h13, 1'b1);

        // Address wrap across the top of the 18-bit space.
        start_burst("t4", 18'h3FFFE, 8'd3);
        do_beat("t4 b0", 18'h3FFFE, 8'hFD, 1'b0);
        do_beat("t4 b1", 18'h3FFFF, 8'hFC, 1'b0);
        do_beat("t4 b2", 18'h00000, 8'h00, 1'b1);

        // len=0 gives one beat; addr_in swapped mid-burst must not matter.
        start_burst("t5", 18'h00020, 8'd0);
        addr_in = 18'h12345;
        do_beat("t5 b0", 18'h00020, 8'h20, 1'b1);

        // Abort in WAIT of beat 2 of 4.
        start_burst("t6", 18'h00040, 8'd4);
        do_beat("t6 b0", 18'h00040, 8'h40, 1'b0);
        step();
        check("t6 b1 mem_rd", 32'(mem_rd), 32'd1);
        check("t6 b1 mem_addr", 32'(mem_addr), 32'h41);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6 abort busy", 32'(busy), 32'd0);
        check("t6 abort mem_addr", 32'(mem_addr), 32'd0);
        stray = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            stray = stray | pix_vld | done | inc_req | busy | mem_rd;
        end
        check("t6 no activity after abort", 32'(stray), 32'd0);
        start_burst("t6r", 18'h00007, 8'd1);
        do_beat("t6r b0", 18'h00007, 8'hA5, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
